// File: rtl/dds_link_pkg.sv
// Shared types and constants for the DDS control link receiver.
// Holds the FSM state enum, link defaults and the crc8 byte-step helper.
package dds_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CRC,
        ST_OUT
    } state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'h5A;
    localparam int         CNT_W       = 16;
    localparam int         MAX_LEN_SUP = 8;
    localparam logic [7:0] CRC8_POLY   = 8'h07;

    // One byte through crc8 (poly 0x07, MSB first).
    function automatic logic [7:0] crc8_byte(
        input logic [7:0] crc,
        input logic [7:0] d
    );
        logic [7:0] c;
        c = crc ^ d;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/crc8.sv
// Registered crc8 engine, poly 0x07, init 0x00, MSB first.
// Ports: clk, rst_n (async low), crc_clr (priority), crc_en, data_in[7:0], crc_out[7:0].
module crc8
    import dds_link_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       crc_en,
    input  logic       crc_clr,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    logic [7:0] crc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else if (crc_clr) begin
            crc_q <= 8'h00;
        end else if (crc_en) begin
            crc_q <= crc8_byte(crc_q, data_in);
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/dds_cmd_frame_rx.sv
// Command-frame receiver: SOF, ADDR, LEN, DATA[LEN], CRC -> one command word.
// Ports: rx_valid/rx_data/rx_ready byte input; cmd_valid/cmd_ready with
// cmd_addr/cmd_len/cmd_data output; err_crc/err_len/err_tmo pulses;
// ok_cnt/bad_cnt saturating frame counters. clk, rst_n async active-low.
module dds_cmd_frame_rx
    import dds_link_pkg::*;
#(
    parameter int         MAX_LEN = 4,
    parameter logic [7:0] SOF     = SOF_DEFAULT,
    parameter int         TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic                 rx_ready,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [7:0]           cmd_addr,
    output logic [3:0]           cmd_len,
    output logic [MAX_LEN*8-1:0] cmd_data,
    output logic                 err_crc,
    output logic                 err_len,
    output logic                 err_tmo,
    output logic [CNT_W-1:0]     ok_cnt,
    output logic [CNT_W-1:0]     bad_cnt
);

    localparam int DW = MAX_LEN * 8;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t           state_q;
    logic [7:0]       addr_q;
    logic [3:0]       len_q;
    logic [3:0]       idx_q;
    logic [DW-1:0]    buf_q;
    logic [TW-1:0]    tmo_q;
    logic             cmd_valid_q;
    logic [7:0]       cmd_addr_q;
    logic [3:0]       cmd_len_q;
    logic [DW-1:0]    cmd_data_q;
    logic             err_crc_q;
    logic             err_len_q;
    logic             err_tmo_q;
    logic [CNT_W-1:0] ok_q;
    logic [CNT_W-1:0] bad_q;

    logic       accept;
    logic       len_ok;
    logic       last_byte;
    logic       crc_clr;
    logic       crc_en;
    logic [7:0] crc_out;

    assign rx_ready  = (state_q != ST_OUT);
    assign accept    = rx_valid && rx_ready;
    assign len_ok    = (rx_data != 8'd0) && (rx_data <= 8'(MAX_LEN));
    assign last_byte = (idx_q == len_q - 4'd1);

    // The CRC byte itself is never folded in; crc_out then already
    // covers ADDR..DATA when the trailer arrives.
    always_comb begin
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        if (accept) begin
            case (state_q)
                ST_IDLE:          crc_clr = (rx_data == SOF);
                ST_ADDR, ST_DATA: crc_en  = 1'b1;
                ST_LEN:           crc_en  = len_ok;
                default:          ;
            endcase
        end
    end

    crc8 u_crc8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .crc_en  (crc_en),
        .crc_clr (crc_clr),
        .data_in (rx_data),
        .crc_out (crc_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            buf_q       <= '0;
            tmo_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            cmd_data_q  <= '0;
            err_crc_q   <= 1'b0;
            err_len_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
            ok_q        <= '0;
            bad_q       <= '0;
        end else begin
            err_crc_q <= 1'b0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tmo_q <= '0;
                    if (accept && rx_data == SOF) begin
                        state_q <= ST_ADDR;
                    end
                end
                ST_OUT: begin
                    if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    // ADDR/LEN/DATA/CRC: a byte on the limit cycle wins.
                    if (accept) begin
                        tmo_q <= '0;
                        case (state_q)
                            ST_ADDR: begin
                                addr_q  <= rx_data;
                                state_q <= ST_LEN;
                            end
                            ST_LEN: begin
                                if (len_ok) begin
                                    len_q   <= rx_data[3:0];
                                    idx_q   <= '0;
                                    buf_q   <= '0;
                                    state_q <= ST_DATA;
                                end else begin
                                    err_len_q <= 1'b1;
                                    bad_q     <= sat_inc(bad_q);
                                    state_q   <= ST_IDLE;
                                end
                            end
                            ST_DATA: begin
                                for (int i = 0; i < MAX_LEN; i++) begin
                                    if (idx_q == 4'(i)) begin
                                        buf_q[i*8 +: 8] <= rx_data;
                                    end
                                end
                                idx_q <= idx_q + 4'd1;
                                if (last_byte) begin
                                    state_q <= ST_CRC;
                                end
                            end
                            ST_CRC: begin
                                if (rx_data == crc_out) begin
                                    cmd_valid_q <= 1'b1;
                                    cmd_addr_q  <= addr_q;
                                    cmd_len_q   <= len_q;
                                    cmd_data_q  <= buf_q;
                                    ok_q        <= sat_inc(ok_q);
                                    state_q     <= ST_OUT;
                                end else begin
                                    err_crc_q <= 1'b1;
                                    bad_q     <= sat_inc(bad_q);
                                    state_q   <= ST_IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end else if (tmo_q == TMO_LAST) begin
                        err_tmo_q <= 1'b1;
                        bad_q     <= sat_inc(bad_q);
                        tmo_q     <= '0;
                        idx_q     <= '0;
                        buf_q     <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_len   = cmd_len_q;
    assign cmd_data  = cmd_data_q;
    assign err_crc   = err_crc_q;
    assign err_len   = err_len_q;
    assign err_tmo   = err_tmo_q;
    assign ok_cnt    = ok_q;
    assign bad_cnt   = bad_q;

endmodule
